// File: rtl/reservation_station_pkg.sv
// Shared parameters for the issue-side reservation station: data width, tag/opcode
// widths and the core-wide ALU-class opcode encoding.
package reservation_station_pkg;

    localparam int DATA_W   = 32;
    localparam int RS_TAG_W = 4;
    localparam int RS_OP_W  = 6;

    localparam logic [RS_OP_W-1:0] OP_LUI   = 6'd1;
    localparam logic [RS_OP_W-1:0] OP_AUIPC = 6'd2;
    localparam logic [RS_OP_W-1:0] OP_JAL   = 6'd3;
    localparam logic [RS_OP_W-1:0] OP_JALR  = 6'd4;
    localparam logic [RS_OP_W-1:0] OP_BEQ   = 6'd5;
    localparam logic [RS_OP_W-1:0] OP_BNE   = 6'd6;
    localparam logic [RS_OP_W-1:0] OP_BLT   = 6'd7;
    localparam logic [RS_OP_W-1:0] OP_BGE   = 6'd8;
    localparam logic [RS_OP_W-1:0] OP_BLTU  = 6'd9;
    localparam logic [RS_OP_W-1:0] OP_BGEU  = 6'd10;
    localparam logic [RS_OP_W-1:0] OP_ADDI  = 6'd11;
    localparam logic [RS_OP_W-1:0] OP_SLTI  = 6'd12;
    localparam logic [RS_OP_W-1:0] OP_SLTIU = 6'd13;
    localparam logic [RS_OP_W-1:0] OP_XORI  = 6'd14;
    localparam logic [RS_OP_W-1:0] OP_ORI   = 6'd15;
    localparam logic [RS_OP_W-1:0] OP_ANDI  = 6'd16;
    localparam logic [RS_OP_W-1:0] OP_SLLI  = 6'd17;
    localparam logic [RS_OP_W-1:0] OP_SRLI  = 6'd18;
    localparam logic [RS_OP_W-1:0] OP_SRAI  = 6'd19;
    localparam logic [RS_OP_W-1:0] OP_ADD   = 6'd20;
    localparam logic [RS_OP_W-1:0] OP_SUB   = 6'd21;
    localparam logic [RS_OP_W-1:0] OP_SLL   = 6'd22;
    localparam logic [RS_OP_W-1:0] OP_SLT   = 6'd23;
    localparam logic [RS_OP_W-1:0] OP_SLTU  = 6'd24;
    localparam logic [RS_OP_W-1:0] OP_XOR   = 6'd25;
    localparam logic [RS_OP_W-1:0] OP_SRL   = 6'd26;
    localparam logic [RS_OP_W-1:0] OP_SRA   = 6'd27;
    localparam logic [RS_OP_W-1:0] OP_OR    = 6'd28;
    localparam logic [RS_OP_W-1:0] OP_AND   = 6'd29;

endpackage

// File: rtl/reservation_station_rs_select.sv
// One-of-N picker: lowest-index request, or oldest request when RS_AGE_ORDER_EN
// is defined and USE_AGE is set. Also used as the free-slot finder.
module rs_select
    import reservation_station_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = $clog2(N),
    parameter int AW = IW + 1
`ifdef RS_AGE_ORDER_EN
    , parameter bit USE_AGE = 1'b1
`endif
) (
    input  logic [N-1:0]    req,
`ifdef RS_AGE_ORDER_EN
    input  logic [N*AW-1:0] age,
`endif
    output logic            vld,
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   idx
);

`ifdef RS_AGE_ORDER_EN
    // Live stamps span less than half the counter range, so a wrapped
    // difference with its MSB set means a was stamped before b.
    function automatic logic older(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW-1:0] d;
        d = a - b;
        return d[AW-1];
    endfunction

    logic [AW-1:0] best_age;
`endif

    always_comb begin
        vld   = 1'b0;
        idx   = '0;
        grant = '0;
`ifdef RS_AGE_ORDER_EN
        best_age = '0;
`endif
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (!vld) begin
                    vld = 1'b1;
                    idx = IW'(i);
`ifdef RS_AGE_ORDER_EN
                    best_age = age[i*AW +: AW];
                end else if (USE_AGE && older(age[i*AW +: AW], best_age)) begin
                    idx      = IW'(i);
                    best_age = age[i*AW +: AW];
`endif
                end
            end
        end
        grant[idx] = vld;
    end

endmodule

// File: rtl/reservation_station.sv
// ALU-class reservation station: dispatch with CDB bypass, two-port wakeup, one
// registered issue per cycle. Define RS_AGE_ORDER_EN for oldest-first issue.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = RS_TAG_W,
    parameter int OP_W    = RS_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              dsp_valid,
    input  logic [OP_W-1:0]   dsp_op,
    input  logic              dsp_q1_busy,
    input  logic              dsp_q2_busy,
    input  logic [TAG_W-1:0]  dsp_q1,
    input  logic [TAG_W-1:0]  dsp_q2,
    input  logic [DATA_W-1:0] dsp_v1,
    input  logic [DATA_W-1:0] dsp_v2,
    input  logic [DATA_W-1:0] dsp_imm,
    input  logic [DATA_W-1:0] dsp_pc,
    input  logic [TAG_W-1:0]  dsp_rob_tag,
    input  logic              cdb0_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [DATA_W-1:0] cdb0_data,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_data,
    output logic              full,
    output logic [OP_W-1:0]   op_to_alu,
    output logic [DATA_W-1:0] v1_to_alu,
    output logic [DATA_W-1:0] v2_to_alu,
    output logic [DATA_W-1:0] imm_to_alu,
    output logic [DATA_W-1:0] pc_to_alu,
    output logic [TAG_W-1:0]  rob_tag_to_rob,
    output logic              is_empty_to_alu
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy, q1_busy, q2_busy, ready;
    logic [OP_W-1:0]    op_e  [RS_SIZE];
    logic [TAG_W-1:0]   q1_e  [RS_SIZE];
    logic [TAG_W-1:0]   q2_e  [RS_SIZE];
    logic [TAG_W-1:0]   rob_e [RS_SIZE];
    logic [DATA_W-1:0]  v1_e  [RS_SIZE];
    logic [DATA_W-1:0]  v2_e  [RS_SIZE];
    logic [DATA_W-1:0]  imm_e [RS_SIZE];
    logic [DATA_W-1:0]  pc_e  [RS_SIZE];

    logic               sel_vld_p0, free_vld_p0, dsp_we_p0;
    logic [RS_SIZE-1:0] sel_grant_p0, free_grant_p0;
    logic [IDX_W-1:0]   sel_idx_p0, free_idx_p0;
    logic               dq1_busy_p0, dq2_busy_p0;
    logic [DATA_W-1:0]  dv1_p0, dv2_p0;

`ifdef RS_AGE_ORDER_EN
    localparam int AGE_W = IDX_W + 1;
    logic [RS_SIZE*AGE_W-1:0] age_flat;
    logic [AGE_W-1:0]         age_cnt;
`endif

    // Operand snoop shared by dispatch bypass and entry wakeup; port 0 wins a tie.
    function automatic logic [DATA_W:0] snoop(input logic pend, input logic [TAG_W-1:0] tag,
                                              input logic [DATA_W-1:0] val);
        if (pend && cdb0_valid && tag == cdb0_tag) return {1'b0, cdb0_data};
        if (pend && cdb1_valid && tag == cdb1_tag) return {1'b0, cdb1_data};
        return {pend, val};
    endfunction

    assign ready     = busy & ~q1_busy & ~q2_busy;
    assign full      = &busy;
    assign dsp_we_p0 = dsp_valid && free_vld_p0 && !flush;
    assign {dq1_busy_p0, dv1_p0} = snoop(dsp_q1_busy, dsp_q1, dsp_v1);
    assign {dq2_busy_p0, dv2_p0} = snoop(dsp_q2_busy, dsp_q2, dsp_v2);

    rs_select #(.N(RS_SIZE)) u_issue_sel (
        .req   (ready),
`ifdef RS_AGE_ORDER_EN
        .age   (age_flat),
`endif
        .vld   (sel_vld_p0),
        .grant (sel_grant_p0),
        .idx   (sel_idx_p0)
    );

    rs_select #(
        .N(RS_SIZE)
`ifdef RS_AGE_ORDER_EN
        , .USE_AGE(1'b0)
`endif
    ) u_free_sel (
        .req   (~busy),
`ifdef RS_AGE_ORDER_EN
        .age   ('0),
`endif
        .vld   (free_vld_p0),
        .grant (free_grant_p0),
        .idx   (free_idx_p0)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~sel_grant_p0) | (dsp_we_p0 ? free_grant_p0 : '0);
        end
    end

`ifdef RS_AGE_ORDER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            age_cnt <= '0;
        end else if (dsp_we_p0) begin
            age_cnt <= age_cnt + 1'b1;
        end
    end
`endif

    // Entry payload: wakeup every cycle, dispatch overwrites the chosen free slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            {q1_busy[i], v1_e[i]} <= snoop(q1_busy[i], q1_e[i], v1_e[i]);
            {q2_busy[i], v2_e[i]} <= snoop(q2_busy[i], q2_e[i], v2_e[i]);
        end
        if (dsp_we_p0) begin
            op_e[free_idx_p0]    <= dsp_op;
            q1_e[free_idx_p0]    <= dsp_q1;
            q2_e[free_idx_p0]    <= dsp_q2;
            q1_busy[free_idx_p0] <= dq1_busy_p0;
            q2_busy[free_idx_p0] <= dq2_busy_p0;
            v1_e[free_idx_p0]    <= dv1_p0;
            v2_e[free_idx_p0]    <= dv2_p0;
            imm_e[free_idx_p0]   <= dsp_imm;
            pc_e[free_idx_p0]    <= dsp_pc;
            rob_e[free_idx_p0]   <= dsp_rob_tag;
`ifdef RS_AGE_ORDER_EN
            age_flat[free_idx_p0*AGE_W +: AGE_W] <= age_cnt;
`endif
        end
    end

    // Issue stage boundary: selected entry registered toward the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_to_alu       <= '0;
            v1_to_alu       <= '0;
            v2_to_alu       <= '0;
            imm_to_alu      <= '0;
            pc_to_alu       <= '0;
            rob_tag_to_rob  <= '0;
            is_empty_to_alu <= 1'b1;
        end else if (flush || !sel_vld_p0) begin
            is_empty_to_alu <= 1'b1;
        end else begin
            op_to_alu       <= op_e[sel_idx_p0];
            v1_to_alu       <= v1_e[sel_idx_p0];
            v2_to_alu       <= v2_e[sel_idx_p0];
            imm_to_alu      <= imm_e[sel_idx_p0];
            pc_to_alu       <= pc_e[sel_idx_p0];
            rob_tag_to_rob  <= rob_e[sel_idx_p0];
            is_empty_to_alu <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station; honours RS_AGE_ORDER_EN for the
// issue-order expectation.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic              clk = 1'b0;
    logic              rst, flush, dsp_valid, dsp_q1_busy, dsp_q2_busy;
    logic [5:0]        dsp_op;
    logic [3:0]        dsp_q1, dsp_q2, dsp_rob_tag;
    logic [31:0]       dsp_v1, dsp_v2, dsp_imm, dsp_pc;
    logic              cdb0_valid, cdb1_valid;
    logic [3:0]        cdb0_tag, cdb1_tag;
    logic [31:0]       cdb0_data, cdb1_data;
    logic              full, is_empty_to_alu;
    logic [5:0]        op_to_alu;
    logic [31:0]       v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;
    logic [3:0]        rob_tag_to_rob;

    int n_checks = 0;
    int n_fail   = 0;

    reservation_station dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dsp_valid(dsp_valid), .dsp_op(dsp_op),
        .dsp_q1_busy(dsp_q1_busy), .dsp_q2_busy(dsp_q2_busy),
        .dsp_q1(dsp_q1), .dsp_q2(dsp_q2), .dsp_v1(dsp_v1), .dsp_v2(dsp_v2),
        .dsp_imm(dsp_imm), .dsp_pc(dsp_pc), .dsp_rob_tag(dsp_rob_tag),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .full(full), .op_to_alu(op_to_alu), .v1_to_alu(v1_to_alu),
        .v2_to_alu(v2_to_alu), .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu),
        .rob_tag_to_rob(rob_tag_to_rob), .is_empty_to_alu(is_empty_to_alu)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dsp_valid = 1'b0; dsp_op = '0; dsp_q1_busy = 1'b0; dsp_q2_busy = 1'b0;
        dsp_q1 = '0; dsp_q2 = '0; dsp_v1 = '0; dsp_v2 = '0;
        dsp_imm = '0; dsp_pc = '0; dsp_rob_tag = '0;
        cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
        cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
        flush = 1'b0;
    endtask

    task automatic dsp(input logic [5:0] op, input logic b1, input logic [3:0] t1,
                       input logic [31:0] v1, input logic b2, input logic [3:0] t2,
                       input logic [31:0] v2, input logic [31:0] imm, input logic [3:0] rob);
        dsp_valid = 1'b1; dsp_op = op;
        dsp_q1_busy = b1; dsp_q1 = t1; dsp_v1 = v1;
        dsp_q2_busy = b2; dsp_q2 = t2; dsp_v2 = v2;
        dsp_imm = imm; dsp_pc = 32'h1000 + {28'd0, rob}; dsp_rob_tag = rob;
    endtask

    initial begin
        logic [3:0] first_rob, second_rob;
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        check_eq("rst_empty", is_empty_to_alu, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_op", op_to_alu, 0);
        check_eq("rst_v1", v1_to_alu, 0);
        check_eq("rst_rob", rob_tag_to_rob, 0);

        // Ready dispatch: written at N, issued at N+1.
        dsp(OP_ADDI, 0, 0, 5, 0, 0, 0, 3, 1);
        tick(); idle();
        check_eq("t1_not_yet", is_empty_to_alu, 1);
        tick();
        check_eq("t1_empty", is_empty_to_alu, 0);
        check_eq("t1_op", op_to_alu, OP_ADDI);
        check_eq("t1_v1", v1_to_alu, 5);
        check_eq("t1_imm", imm_to_alu, 3);
        check_eq("t1_pc", pc_to_alu, 32'h1001);
        check_eq("t1_rob", rob_tag_to_rob, 1);
        tick();
        check_eq("t1_after", is_empty_to_alu, 1);

        // Operand waits on tag 7, woken by cdb1.
        dsp(OP_ADD, 1, 7, 0, 0, 0, 2, 0, 2);
        tick(); idle();
        tick();
        check_eq("t2_wait", is_empty_to_alu, 1);
        cdb1_valid = 1'b1; cdb1_tag = 7; cdb1_data = 32'h10;
        tick(); idle();
        check_eq("t2_wake_edge", is_empty_to_alu, 1);
        tick();
        check_eq("t2_empty", is_empty_to_alu, 0);
        check_eq("t2_v1", v1_to_alu, 32'h10);
        check_eq("t2_v2", v2_to_alu, 2);
        check_eq("t2_rob", rob_tag_to_rob, 2);

        // Dispatch bypass from cdb0 in the same cycle.
        dsp(OP_SUB, 0, 0, 1, 1, 3, 0, 0, 3);
        cdb0_valid = 1'b1; cdb0_tag = 3; cdb0_data = 32'hAB;
        tick(); idle();
        tick();
        check_eq("t3_empty", is_empty_to_alu, 0);
        check_eq("t3_v2", v2_to_alu, 32'hAB);
        check_eq("t3_v1", v1_to_alu, 1);
        check_eq("t3_rob", rob_tag_to_rob, 3);
        tick();

        // Fill all 16 entries; entry 0 waits on tag 9, others on tag 8.
        for (int i = 0; i < 16; i++) begin
            dsp(OP_OR, 1, (i == 0) ? 4'd9 : 4'd8, 0, 0, 0, 0, 0, 4'(i));
            tick();
            if (i == 14) check_eq("t4_not_full", full, 0);
        end
        idle();
        check_eq("t4_full", full, 1);
        dsp(OP_XOR, 0, 0, 9, 0, 0, 9, 0, 15);
        tick(); idle();
        tick();
        check_eq("t4_17th_ignored", is_empty_to_alu, 1);
        check_eq("t4_still_full", full, 1);
        cdb0_valid = 1'b1; cdb0_tag = 9; cdb0_data = 32'h55;
        tick(); idle();
        check_eq("t4_full_at_wake", full, 1);
        tick();
        check_eq("t4_issue", is_empty_to_alu, 0);
        check_eq("t4_rob", rob_tag_to_rob, 0);
        check_eq("t4_v1", v1_to_alu, 32'h55);
        check_eq("t4_full_clear", full, 0);
        flush = 1'b1;
        tick(); idle();
        check_eq("t4_flush_full", full, 0);
        check_eq("t4_flush_empty", is_empty_to_alu, 1);

        // Flush with a simultaneous ready dispatch while 4 entries are busy.
        for (int i = 0; i < 4; i++) begin
            dsp(OP_AND, 1, 8, 0, 0, 0, 0, 0, 4'(i + 4));
            tick();
        end
        idle();
        flush = 1'b1;
        dsp(OP_ADDI, 0, 0, 1, 0, 0, 0, 1, 13);
        tick(); idle();
        check_eq("t6_empty", is_empty_to_alu, 1);
        check_eq("t6_full", full, 0);
        tick();
        check_eq("t6_no_issue", is_empty_to_alu, 1);
        cdb0_valid = 1'b1; cdb0_tag = 8; cdb0_data = 32'h88;
        tick(); idle();
        tick();
        check_eq("t6_no_wake_issue", is_empty_to_alu, 1);

        // Age order: idx5 holds an older instruction than the refilled idx2.
        for (int i = 0; i < 6; i++) begin
            dsp(OP_ADD, 1, (i == 2) ? 4'd2 : (i == 5) ? 4'd5 : 4'd15, 0, 0, 0, 0, 0, 4'(i));
            tick();
        end
        idle();
        cdb0_valid = 1'b1; cdb0_tag = 2; cdb0_data = 32'h22;
        tick(); idle();
        tick();
        check_eq("t5_free_issue", is_empty_to_alu, 0);
        check_eq("t5_free_rob", rob_tag_to_rob, 2);
        dsp(OP_ADD, 1, 6, 0, 0, 0, 0, 0, 12);
        tick(); idle();
        cdb0_valid = 1'b1; cdb0_tag = 5; cdb0_data = 32'h5;
        cdb1_valid = 1'b1; cdb1_tag = 6; cdb1_data = 32'h6;
        tick(); idle();
`ifdef RS_AGE_ORDER_EN
        first_rob = 5; second_rob = 12;
`else
        first_rob = 12; second_rob = 5;
`endif
        tick();
        check_eq("t5_first_vld", is_empty_to_alu, 0);
        check_eq("t5_first_rob", rob_tag_to_rob, first_rob);
        tick();
        check_eq("t5_second_vld", is_empty_to_alu, 0);
        check_eq("t5_second_rob", rob_tag_to_rob, second_rob);
        tick();
        check_eq("t5_drained", is_empty_to_alu, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Issue-side reservation station for the out-of-order RISC-V core. Buffers decoded ALU-class instructions (LUI through AND, including branches and JAL/JALR) from the dispatcher and tracks operand tags until both values are known. Snoops two common-data-bus ports for wakeup. Issues at most one ready entry per cycle, registered, to the ALU, whose combinational result is captured by the ROB in the following cycle.

## Interface
- RS_SIZE, 16: number of entries, power of two, 2..32.
- TAG_W, 4: ROB tag width.
- OP_W, 6: internal opcode width, matching the shared opcode encoding.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  ROB mispredict clear; discards all entries.
- dsp_valid  in  1  dispatch request this cycle.
- dsp_op  in  OP_W  opcode.
- dsp_q1_busy, dsp_q2_busy  in  1 each  operand still pending.
- dsp_q1, dsp_q2  in  TAG_W each  producer ROB tag, meaningful when busy.
- dsp_v1, dsp_v2  in  32 each  operand values, meaningful when not busy.
- dsp_imm, dsp_pc, dsp_rob_tag  in  32/32/TAG_W  immediate, PC, destination tag.
- cdb0_valid, cdb0_tag, cdb0_data  in  1/TAG_W/32  broadcast port 0 (ROB commit of ALU results).
- cdb1_valid, cdb1_tag, cdb1_data  in  1/TAG_W/32  broadcast port 1 (load/store buffer).
- full  out  1  no free entry.
- op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu  out  OP_W/32/32/32/32  issued instruction.
- rob_tag_to_rob  out  TAG_W  tag of the issued instruction.
- is_empty_to_alu  out  1  high when nothing is issued this cycle.

## Operation
- Each entry holds: busy, op, q1_busy, q1, v1, q2_busy, q2, v2, imm, pc, rob_tag, plus an age stamp when RS_AGE_ORDER_EN is defined.
- Dispatch: when dsp_valid and not full, write the lowest-index free entry.
- Dispatch bypass, always present: if dsp_qN_busy and a valid CDB port matches dsp_qN in the same cycle, store that port's data and clear qN_busy.
- Wakeup: every busy entry with qN_busy and a tag matching a valid CDB port captures the data and clears qN_busy. If both ports match the same tag, port 0 wins; this case is an upstream error.
- Ready condition: busy and not q1_busy and not q2_busy.
- Select: exactly one ready entry per cycle. The selection policy is set under Configuration.
- Issue: the selected entry's fields are registered onto the *_to_alu outputs and rob_tag_to_rob, is_empty_to_alu is driven low, and the entry is freed at the same edge.
- When no entry is ready: is_empty_to_alu = 1. Data outputs hold their last values, and downstream ignores them.
- Entries woken at edge N are not ready until the cycle after edge N; wakeup and selection are never combined in one cycle.
- full = (number of busy entries == RS_SIZE), computed from registered state. Dispatch while full is a protocol violation; the request is ignored and entries are untouched.
- Simultaneous dispatch and issue: both occur, and a freed slot is not reusable in the same cycle.
- flush: at the next edge all busy bits clear and is_empty_to_alu = 1. flush has priority over dispatch, wakeup and issue in the same cycle.
- Reset: all entries free, full = 0, is_empty_to_alu = 1, all other outputs 0.

## Timing
- Dispatch with both operands ready at edge N: entry written at N, issued at edge N+1, ROB captures the ALU result at N+2.
- Operand broadcast at edge N on a waiting entry: value captured at N, issue at N+1 at the earliest.
- Dispatch-bypass case: behaves identically to dispatch with ready operands.
- Throughput: one issue per cycle sustained.
- full reflects state after the last edge. There is no combinational path from dsp_valid to full.
- No combinational path from any input to any output.

## Configuration
- RS_AGE_ORDER_EN defined: each entry carries an age stamp from a wrapping dispatch counter of width log2(RS_SIZE)+1. Among ready entries the oldest issues, with age compared modulo the counter width. Ties are impossible.
- RS_AGE_ORDER_EN undefined: the lowest-index ready entry issues. No age storage.

## Structure
- Opcode defines (LUI..AND), the data width and TAG_W default belong in the shared parameters package. No local opcode constants.
- Sub-module rs_select: ready-bit vector in (plus age vector when enabled), outputs a valid bit and a one-hot/index grant. It also provides the free-slot picker as a second instance on the inverted busy vector.

## Test plan
- After reset: dispatch ADDI (v1 = 5, imm = 3, both ready) -> next cycle op_to_alu = ADDI, v1_to_alu = 5, imm_to_alu = 3, is_empty_to_alu = 0. Following cycle is_empty_to_alu = 1.
- Dispatch ADD with q1_busy, q1 = 7; cdb1 broadcasts tag 7, data 0x10 two cycles later -> issue the cycle after the broadcast with v1_to_alu = 0x10.
- Dispatch with q2 = 3 while cdb0 broadcasts tag 3, data 0xAB in the same cycle -> issue next cycle with v2_to_alu = 0xAB.
- Fill 16 entries with unready operands -> full = 1. A 17th dispatch is ignored. One wakeup plus issue -> full = 0 the cycle after the issue.
- Two entries become ready in the same cycle (index 5 dispatched first, index 2 second) -> with RS_AGE_ORDER_EN index 5 issues first, without it index 2 issues first.
- flush asserted together with dsp_valid while 4 entries are busy -> next cycle is_empty_to_alu = 1 and full = 0, and nothing issues until a new dispatch.
